// File: rtl/led_driver_pkg.sv
// Shared types, glyph table and LED mask helper for the multi-channel LED bar driver.
package led_driver_pkg;

    typedef enum logic {
        DOT = 1'b0,
        BAR = 1'b1
    } mode_t;

    localparam int unsigned LED_MAX   = 16;
    localparam int unsigned LED_MAX_X = LED_MAX + 1;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // {g,f,e,d,c,b,a} glyphs, index = hex digit
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // One-hot at pos for DOT, thermometer 0..pos for BAR; one spare bit avoids overflow at pos=15
    function automatic logic [LED_MAX-1:0] led_mask(input mode_t mode, input logic [3:0] pos);
        logic [LED_MAX_X-1:0] one_hot;
        one_hot = LED_MAX_X'(1) << pos;
        if (mode == BAR) begin
            return LED_MAX'((one_hot << 1) - LED_MAX_X'(1));
        end
        return LED_MAX'(one_hot);
    endfunction

endpackage

// File: rtl/led_seg_decoder.sv
// Hex value to active-high 7-segment pattern {dp,g,f,e,d,c,b,a}, with blanking.
module led_seg_decoder
    import led_driver_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       blank_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            seg_o = {dp_i, SEG_HEX[value_i]};
        end
    end

endmodule

// File: rtl/led_driver_multi.sv
// N-channel LED bar driver with shared edge-detected buttons and per-channel hex digit.
// Optional auto-step prescaler enabled by defining LED_AUTO_STEP_EN.
module led_driver_multi
    import led_driver_pkg::*;
#(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned W_LED    = 5,
    parameter int unsigned STEP_DIV = 50_000_000
) (
    input  logic                    clk,
    input  logic                    async_reset,
    input  logic                    btn_next,
    input  logic                    btn_mode,
    input  logic                    btn_cyclic,
    input  logic [N_CH-1:0]         sw_sel,
    output logic [N_CH*W_LED-1:0]   led_output,
    output logic [N_CH*8-1:0]       seg
);

    localparam int unsigned PW = $clog2(W_LED);
    localparam logic [PW-1:0] POS_MAX = PW'(W_LED - 1);

    if (N_CH < 1 || N_CH > 8 || W_LED < 2 || W_LED > LED_MAX || STEP_DIV < 1) begin : g_param_check
        $error("led_driver_multi: parameter out of range");
    end

    logic             btn_next_q, btn_mode_q, btn_cyclic_q;
    logic             rise_next_c, rise_mode_c, rise_cyclic_c;
    logic             auto_tick_c;
    logic [PW-1:0]    pos_q    [N_CH];
    logic [PW-1:0]    pos_d    [N_CH];
    mode_t            mode_q   [N_CH];
    mode_t            mode_d   [N_CH];
    logic             cyclic_q [N_CH];
    logic             cyclic_d [N_CH];

    assign rise_next_c   = btn_next   & ~btn_next_q;
    assign rise_mode_c   = btn_mode   & ~btn_mode_q;
    assign rise_cyclic_c = btn_cyclic & ~btn_cyclic_q;

`ifdef LED_AUTO_STEP_EN
    localparam int unsigned PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;

    assign auto_tick_c = (pre_q == PRE_LAST);
    assign pre_d       = auto_tick_c ? '0 : pre_q + PRE_W'(1);
`else
    assign auto_tick_c = 1'b0;
`endif

    // Next-state per channel; a tick coinciding with a button press advances only once
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            pos_d[i]    = pos_q[i];
            mode_d[i]   = mode_q[i];
            cyclic_d[i] = cyclic_q[i];
            if (sw_sel[i]) begin
                if (rise_next_c || auto_tick_c) begin
                    if (pos_q[i] == POS_MAX) begin
                        pos_d[i] = cyclic_q[i] ? '0 : POS_MAX;
                    end else begin
                        pos_d[i] = pos_q[i] + PW'(1);
                    end
                end
                if (rise_mode_c) begin
                    mode_d[i] = (mode_q[i] == DOT) ? BAR : DOT;
                end
                if (rise_cyclic_c) begin
                    cyclic_d[i] = ~cyclic_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            btn_next_q   <= 1'b0;
            btn_mode_q   <= 1'b0;
            btn_cyclic_q <= 1'b0;
`ifdef LED_AUTO_STEP_EN
            pre_q        <= '0;
`endif
            for (int i = 0; i < N_CH; i++) begin
                pos_q[i]    <= '0;
                mode_q[i]   <= DOT;
                cyclic_q[i] <= 1'b0;
            end
        end else begin
            btn_next_q   <= btn_next;
            btn_mode_q   <= btn_mode;
            btn_cyclic_q <= btn_cyclic;
`ifdef LED_AUTO_STEP_EN
            pre_q        <= pre_d;
`endif
            for (int i = 0; i < N_CH; i++) begin
                pos_q[i]    <= pos_d[i];
                mode_q[i]   <= mode_d[i];
                cyclic_q[i] <= cyclic_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign led_output[g*W_LED +: W_LED] = W_LED'(led_mask(mode_q[g], 4'(pos_q[g])));

        led_seg_decoder u_seg (
            .value_i (4'(pos_q[g])),
            .blank_i (~sw_sel[g]),
            .dp_i    (cyclic_q[g]),
            .seg_o   (seg[g*8 +: 8])
        );
    end

endmodule
